vga_timing_controller: RTL
==========================

// Module: vga_timing_controller
// PURPOSE
//  Sequences the VGA pixel datapath from the 100 MHz system clock. An internal prescaler produces
//  a one-clk pixel_tick every DIV clocks; this replaces the free-running toggle divider with a
//  clock enable. H/V counters and the sync, blanking and frame strobes are registered and advance
//  only on pixel_tick. It sits between the system clock and the pixel generator/RGB mux.
// PARAMETERS
//  DIV       4    clk cycles per pixel (>=1); 4 gives 25 MHz pixel rate from 100 MHz
//  H_ACTIVE  640  visible pixels per line
//  H_FP      16   horizontal front porch, pixels
//  H_SYNC    96   hsync pulse width, pixels
//  H_BP      48   horizontal back porch, pixels (H_TOTAL = 800)
//  V_ACTIVE  480  visible lines per frame
//  V_FP      10   vertical front porch, lines
//  V_SYNC    2    vsync pulse width, lines
//  V_BP      33   vertical back porch, lines (V_TOTAL = 525)
//  SYNC_POL  0    asserted sync level (0 = active-low, standard 640x480)
// PORTS
//  clk          in   1   system clock; all logic on posedge
//  reset        in   1   synchronous, active-high reset
//  enable       in   1   run; 0 freezes prescaler, counters and all outputs
//  pixel_tick   out  1   1-clk pulse: new pixel position presented this cycle
//  hcount       out  10  horizontal position, 0..H_TOTAL-1
//  vcount       out  10  vertical position, 0..V_TOTAL-1
//  hsync        out  1   horizontal sync at SYNC_POL level when asserted
//  vsync        out  1   vertical sync at SYNC_POL level when asserted
//  video_on     out  1   1 iff hcount<H_ACTIVE && vcount<V_ACTIVE
//  line_start   out  1   1-clk pulse when hcount newly becomes 0
//  frame_start  out  1   1-clk pulse when (hcount,vcount) newly becomes (0,0)
// BEHAVIOUR
//  - Reset: prescaler=0, hcount=H_TOTAL-1, vcount=V_TOTAL-1, pixel_tick=0, video_on=0,
//    line_start=0, frame_start=0, hsync=vsync=~SYNC_POL (deasserted). Applies from any state.
//  - Prescaler p counts 0..DIV-1 while enable=1. On the edge where p==DIV-1: p<=0, pixel_tick<=1,
//    counters advance and all decoded outputs update on that same edge (no skew vs hcount/vcount).
//  - pixel_tick=0 in all other cycles; with continuous enable the period is exactly DIV clks.
//    DIV=1 gives pixel_tick held high.
//  - Advance: hcount+1; at H_TOTAL-1 wraps to 0 and vcount+1; vcount at V_TOTAL-1 wraps to 0.
//  - Decoded outputs are registered from the next count values, never combinational from counters.
//  - hsync asserted iff H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC.
//  - vsync asserted iff V_ACTIVE+V_FP <= vcount < V_ACTIVE+V_FP+V_SYNC.
//  - line_start/frame_start high only in the pixel_tick cycle that lands on hcount=0 / (0,0).
//    They are 0 in every other clk, including while frozen.
//  - enable=0: p, counts, hsync, vsync, video_on hold; pixel_tick, line_start, frame_start are 0.
//    Re-enable resumes from the held p with no extra pixel.
//  - reset and enable both high: reset wins.
//  - First pixel_tick after reset lands on (0,0) with frame_start=line_start=video_on=1.
// TESTING (defaults, DIV=4)
//  1. reset 2 clks, then enable=1 continuously -> pixel_tick on 4th edge after enable is sampled;
//     hcount=0, vcount=0, frame_start=1, line_start=1, video_on=1; ticks every 4 clks after.
//  2. Run one line -> hsync=0 exactly for hcount 656..751 (96 ticks); hsync=1 at 655 and 752;
//     video_on=0 from hcount 640.
//  3. hcount 799 -> next tick hcount=0, vcount+1, line_start for 1 clk, frame_start=0;
//     vcount 479->480 drops video_on for the whole line.
//  4. Full frame -> vsync=0 for vcount 490..491 only; frame_start pulses 1,680,000 clks apart
//     (800*525*4).
//  5. Drop enable for 37 clks mid-line at hcount=300 -> all outputs frozen, no pulses;
//     resumes 301 next.
//     Assert reset at (200,100) -> next edge hcount=799, vcount=524, video_on=0, syncs deasserted.
//  6. DIV=1 build -> pixel_tick constant 1 after reset; frame_start every 420,000 clks.

Source files
------------

// File: rtl/vga_timing_controller.sv
// VGA raster timing generator: a clock-enable prescaler drives H/V counters and
// the registered sync, blanking, line and frame strobes derived from them.
module vga_timing_controller #(
  parameter int   DIV      = 4,
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  output logic       pixel_tick,
  output logic [9:0] hcount,
  output logic [9:0] vcount,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       line_start,
  output logic       frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT        = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT        = 10'(V_ACTIVE);
  localparam logic [9:0] H_SYNC_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_SYNC_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] V_SYNC_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_SYNC_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  // Prescaler keeps at least one bit so DIV=1 still elaborates.
  localparam int            PW     = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(DIV - 1);

  logic [PW-1:0] p;
  logic [9:0]    h_next;
  logic [9:0]    v_next;
  logic          h_sync_next;
  logic          v_sync_next;
  logic          video_next;

  // NOTE: every output of a combinational block gets a default first, so no path
  // through it can leave a signal unassigned and infer a latch.
  always_comb begin
    h_next = hcount + 10'd1;
    v_next = vcount;
    if (hcount == H_LAST) begin
      h_next = '0;
      v_next = (vcount == V_LAST) ? '0 : vcount + 10'd1;
    end
    h_sync_next = (h_next >= H_SYNC_START) && (h_next < H_SYNC_END);
    v_sync_next = (v_next >= V_SYNC_START) && (v_next < V_SYNC_END);
    video_next  = (h_next < H_ACT) && (v_next < V_ACT);
  end

  // NOTE: registered state uses non-blocking assignments so every flop samples the
  // pre-edge values and the ordering of statements cannot change the result.
  always_ff @(posedge clk) begin
    if (reset) begin
      p           <= '0;
      hcount      <= H_LAST;
      vcount      <= V_LAST;
      pixel_tick  <= 1'b0;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      video_on    <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      pixel_tick  <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      if (enable) begin
        if (p == P_LAST) begin
          // Counters and every decode update together so they never skew.
          p           <= '0;
          pixel_tick  <= 1'b1;
          hcount      <= h_next;
          vcount      <= v_next;
          hsync       <= h_sync_next ? SYNC_POL : ~SYNC_POL;
          vsync       <= v_sync_next ? SYNC_POL : ~SYNC_POL;
          video_on    <= video_next;
          line_start  <= (h_next == 10'd0);
          frame_start <= (h_next == 10'd0) && (v_next == 10'd0);
        end else begin
          p <= p + PW'(1);
        end
      end
    end
  end

endmodule
